// File: rtl/tof_pkg.sv
// Shared ToF definitions: channel/frame geometry, scheduler states and comm command codes.
package tof_pkg;

   localparam int unsigned NB_OF_SENSORS = 8;
   localparam int unsigned NB_ZONES      = 64;
   localparam int unsigned DATA_W        = 16;

   localparam logic [3:0] INIT_SENSOR   = 4'h1;
   localparam logic [3:0] INIT_FINISHED = 4'h2;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      FETCH,
      CAPTURE,
      SEND
   } sched_state_t;

endpackage

// File: rtl/tof_rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr, wrapping modulo NB_REQ.
module tof_rr_arbiter #(
   parameter int unsigned NB_REQ = 8,
   parameter int unsigned IDX_W  = 3
) (
   input  logic [NB_REQ-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [IDX_W-1:0]  grant,
   output logic              any_req
);

   logic [IDX_W-1:0] idx;
   logic             found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         idx = IDX_W'((32'(ptr) + k) % NB_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
      any_req = |req;
   end

endmodule

// File: rtl/tof_readout_scheduler.sv
// Round-robin drain of completed ToF frames into one tagged 16-bit valid/ready stream.
// Optional per-sensor staleness watchdog (stale port) enabled by defining TOF_SCHED_STALE_EN.
module tof_readout_scheduler #(
   parameter int unsigned NB_OF_SENSORS = tof_pkg::NB_OF_SENSORS,
   parameter int unsigned IDX_W         = 3,
   parameter int unsigned NB_ZONES      = tof_pkg::NB_ZONES,
   parameter int unsigned ZONE_W        = 6,
   parameter int unsigned DATA_W        = tof_pkg::DATA_W
`ifdef TOF_SCHED_STALE_EN
   ,
   parameter logic [23:0] STALE_CYCLES  = 24'd10_000_000
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NB_OF_SENSORS-1:0] ready_in,
   output logic [IDX_W-1:0]         tof_index,
   output logic [ZONE_W-1:0]        zone_idx,
   input  logic [DATA_W-1:0]        zone_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [IDX_W-1:0]         out_sensor,
   output logic [ZONE_W-1:0]        out_zone,
   output logic                     out_last,
   output logic                     frame_done,
   output logic                     busy,
   output logic [NB_OF_SENSORS-1:0] pending
`ifdef TOF_SCHED_STALE_EN
   ,
   output logic [NB_OF_SENSORS-1:0] stale
`endif
);

   import tof_pkg::*;

   sched_state_t             state_q, state_d;
   logic [NB_OF_SENSORS-1:0] pending_q, pending_d;
   logic [NB_OF_SENSORS-1:0] eligible;
   logic [IDX_W-1:0]         rr_q, rr_d;
   logic [IDX_W-1:0]         tof_index_q, tof_index_d;
   logic [ZONE_W-1:0]        zone_q, zone_d;
   logic [DATA_W-1:0]        out_data_q, out_data_d;
   logic [IDX_W-1:0]         out_sensor_q, out_sensor_d;
   logic [ZONE_W-1:0]        out_zone_q, out_zone_d;
   logic                     out_last_q, out_last_d;
   logic                     out_valid_q, out_valid_d;
   logic                     frame_done_q, frame_done_d;
   logic [IDX_W-1:0]         grant;
   logic                     any_req;

`ifdef TOF_SCHED_STALE_EN
   logic [23:0] stale_cnt_q [NB_OF_SENSORS];

   // Counter restarts on every ready flag and parks at the limit until the next one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NB_OF_SENSORS; i++) begin
            stale_cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NB_OF_SENSORS; i++) begin
            if (ready_in[i]) begin
               stale_cnt_q[i] <= '0;
            end else if (stale_cnt_q[i] != STALE_CYCLES) begin
               stale_cnt_q[i] <= stale_cnt_q[i] + 24'd1;
            end
         end
      end
   end

   always_comb begin
      stale = '0;
      for (int unsigned i = 0; i < NB_OF_SENSORS; i++) begin
         stale[i] = (stale_cnt_q[i] == STALE_CYCLES);
      end
   end

   assign eligible = pending_q & ~stale;
`else
   assign eligible = pending_q;
`endif

   tof_rr_arbiter #(
      .NB_REQ (NB_OF_SENSORS),
      .IDX_W  (IDX_W)
   ) u_arbiter (
      .req     (eligible),
      .ptr     (rr_q),
      .grant   (grant),
      .any_req (any_req)
   );

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q | ready_in;
      rr_d         = rr_q;
      tof_index_d  = tof_index_q;
      zone_d       = zone_q;
      out_data_d   = out_data_q;
      out_sensor_d = out_sensor_q;
      out_zone_d   = out_zone_q;
      out_last_d   = out_last_q;
      out_valid_d  = out_valid_q;
      frame_done_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (enable && (|eligible)) begin
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (any_req) begin
               tof_index_d = grant;
               zone_d      = '0;
               rr_d        = (grant == IDX_W'(NB_OF_SENSORS - 1)) ? '0 : grant + 1'b1;
               // A flag arriving in the grant cycle for the granted sensor survives the clear.
               pending_d   = (pending_q & ~(NB_OF_SENSORS'(1) << grant)) | ready_in;
               state_d     = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            out_data_d   = zone_data;
            out_sensor_d = tof_index_q;
            out_zone_d   = zone_q;
            out_last_d   = (zone_q == ZONE_W'(NB_ZONES - 1));
            out_valid_d  = 1'b1;
            state_d      = SEND;
         end
         SEND: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  frame_done_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  zone_d  = zone_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         rr_q         <= '0;
         tof_index_q  <= '0;
         zone_q       <= '0;
         out_data_q   <= '0;
         out_sensor_q <= '0;
         out_zone_q   <= '0;
         out_last_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         rr_q         <= rr_d;
         tof_index_q  <= tof_index_d;
         zone_q       <= zone_d;
         out_data_q   <= out_data_d;
         out_sensor_q <= out_sensor_d;
         out_zone_q   <= out_zone_d;
         out_last_q   <= out_last_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tof_index  = tof_index_q;
   assign zone_idx   = zone_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_sensor = out_sensor_q;
   assign out_zone   = out_zone_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != IDLE);
   assign pending    = pending_q;

endmodule

// File: tb/tb_tof_readout_scheduler.sv
// Self-checking bench for tof_readout_scheduler: frame-level reference model plus directed and random traffic.
module tb_tof_readout_scheduler;

   localparam int N  = 8;
   localparam int NZ = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  ready_in = '0;
   logic [2:0]  tof_index;
   logic [5:0]  zone_idx;
   logic [15:0] zone_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [2:0]  out_sensor;
   logic [5:0]  out_zone;
   logic        out_last;
   logic        frame_done;
   logic        busy;
   logic [7:0]  pending;
`ifdef TOF_SCHED_STALE_EN
   logic [7:0]  stale;
`endif

   tof_readout_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .ready_in   (ready_in),
      .tof_index  (tof_index),
      .zone_idx   (zone_idx),
      .zone_data  (zone_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sensor (out_sensor),
      .out_zone   (out_zone),
      .out_last   (out_last),
      .frame_done (frame_done),
      .busy       (busy),
      .pending    (pending)
`ifdef TOF_SCHED_STALE_EN
      ,
      .stale      (stale)
`endif
   );

   always #5 clk = ~clk;

   bit mix = 1'b0;

   function automatic logic [15:0] word_of(input logic [2:0] s, input logic [5:0] z, input bit mx);
      int v;
      v = mx ? (int'(s) * 1000 + int'(z) * 10) : int'(z) * 10;
      return 16'(v);
   endfunction

   // Readout mux with one cycle of latency after the select changes.
   always @(posedge clk) zone_data <= word_of(tof_index, zone_idx, mix);

   int vectors = 0;
   int miscompares = 0;

   // Reference model state (expected DUT outputs for the current cycle).
   logic [2:0]  e_tof, e_sensor;
   logic [5:0]  e_zone, e_ozone;
   logic [15:0] e_data;
   logic        e_valid, e_last, e_done, e_busy;
   logic [7:0]  e_pending;
   int          m_rr, m_ph, m_wait;   // m_ph: 0 idle, 1 arbitrating, 2 transferring
   int          busy_cycles, done_cnt;
   logic [25:0] acc[$];               // {last, sensor, zone, data} of each accepted word

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      e_tof = '0; e_sensor = '0; e_zone = '0; e_ozone = '0; e_data = '0;
      e_valid = 1'b0; e_last = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_pending = '0;
      m_rr = 0; m_ph = 0; m_wait = 0;
   endtask

   task automatic model_step();
      logic [7:0] p;
      int g;
      p = e_pending | ready_in;
      e_done = 1'b0;
      if (m_ph == 0) begin
         if (enable && e_pending != 0) m_ph = 1;
      end else if (m_ph == 1) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && e_pending[(m_rr + k) % N]) g = (m_rr + k) % N;
         end
         if (g < 0) begin
            m_ph = 0;
         end else begin
            e_tof  = 3'(g);
            e_zone = '0;
            m_rr   = (g + 1) % N;
            p      = (e_pending & ~(8'd1 << g)) | ready_in;
            m_wait = 2;
            m_ph   = 2;
         end
      end else begin
         if (!e_valid) begin
            m_wait--;
            if (m_wait == 0) begin
               e_valid  = 1'b1;
               e_data   = word_of(e_tof, e_zone, mix);
               e_sensor = e_tof;
               e_ozone  = e_zone;
               e_last   = (e_zone == 6'(NZ - 1));
            end
         end else if (out_ready) begin
            e_valid = 1'b0;
            if (e_last) begin
               e_done = 1'b1;
               m_ph   = 0;
            end else begin
               e_zone = e_zone + 6'd1;
               m_wait = 2;
            end
         end
      end
      e_pending = p;
      e_busy    = (m_ph != 0);
   endtask

   task automatic compare_all();
      chk("tof_index",  32'(tof_index),  32'(e_tof));
      chk("zone_idx",   32'(zone_idx),   32'(e_zone));
      chk("out_valid",  32'(out_valid),  32'(e_valid));
      chk("out_data",   32'(out_data),   32'(e_data));
      chk("out_sensor", 32'(out_sensor), 32'(e_sensor));
      chk("out_zone",   32'(out_zone),   32'(e_ozone));
      chk("out_last",   32'(out_last),   32'(e_last));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("pending",    32'(pending),    32'(e_pending));
   endtask

   // Inputs set before the call are sampled at the coming posedge; outputs checked at the next negedge.
   task automatic tick();
      if (e_valid && out_ready) acc.push_back({e_last, e_sensor, e_ozone, e_data});
      model_step();
      @(negedge clk);
      compare_all();
      if (e_busy) busy_cycles++;
      if (e_done) done_cnt++;
   endtask

   task automatic pulse(input logic [7:0] r);
      ready_in = r;
      tick();
      ready_in = '0;
   endtask

   task automatic run_frames(input int n, input int budget, input string name);
      int start;
      int c;
      start = done_cnt;
      c = 0;
      while (done_cnt - start < n && c < budget) begin
         tick();
         c++;
      end
      chk({name, "_frames"}, 32'(done_cnt - start), 32'(n));
   endtask

   task automatic wait_word(input logic [2:0] s, input logic [5:0] z, input string name);
      int c;
      c = 0;
      while (!(e_valid && e_sensor == s && e_ozone == z) && c < 600) begin
         tick();
         c++;
      end
      chk({name, "_reached"}, 32'(c < 600), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   function automatic logic [2:0] sens_at(input int i);
      logic [25:0] w;
      w = (i < acc.size()) ? acc[i] : '0;
      return w[24:22];
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [25:0] w;
      int bad;
      int lasts;
      bit stable;

      model_reset();
      busy_cycles = 0;
      done_cnt = 0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid",  32'(out_valid),  32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_tof_index",  32'(tof_index),  32'd0);
      chk("rst_pending",    32'(pending),    32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      reset = 1'b1;

      // Single frame from sensor 2, data = zone*10.
      enable = 1'b1; out_ready = 1'b1; mix = 1'b0;
      acc.delete();
      busy_cycles = 0;
      pulse(8'h04);
      run_frames(1, 400, "single");
      chk("single_tof_index", 32'(tof_index), 32'd2);
      chk("single_count", 32'(acc.size()), 32'd64);
      bad = 0; lasts = 0;
      for (int i = 0; i < acc.size(); i++) begin
         w = acc[i];
         if (w[24:22] != 3'd2 || int'(w[21:16]) != i || int'(w[15:0]) != i * 10) bad++;
         if (w[25]) lasts++;
      end
      chk("single_words", 32'(bad), 32'd0);
      chk("single_lasts", 32'(lasts), 32'd1);
      w = (acc.size() > 0) ? acc[acc.size() - 1] : '0;
      chk("single_last_word", {6'd0, w}, {6'd0, 1'b1, 3'd2, 6'd63, 16'd630});
      chk("single_busy_cycles", 32'(busy_cycles), 32'd193);
      repeat (3) tick();
      chk("single_idle", 32'(busy), 32'd0);

      // Round robin from a fresh pointer: 0 then 7, twice (pointer wraps 7->0).
      do_reset();
      for (int r = 0; r < 2; r++) begin
         acc.delete();
         pulse(8'h81);
         run_frames(2, 800, "rr");
         chk("rr_first",  32'(sens_at(0)),  32'd0);
         chk("rr_second", 32'(sens_at(64)), 32'd7);
      end

      // Backpressure at zone 5 of sensor 5.
      mix = 1'b1;
      acc.delete();
      pulse(8'h20);
      wait_word(3'd5, 6'd5, "bp");
      out_ready = 1'b0;
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (!(out_valid && out_zone == 6'd5 && out_data == word_of(3'd5, 6'd5, 1'b1))) stable = 1'b0;
      end
      chk("bp_stable", 32'(stable), 32'd1);
      out_ready = 1'b1;
      run_frames(1, 400, "bp");
      bad = 0;
      for (int i = 0; i < acc.size(); i++) begin
         w = acc[i];
         if (int'(w[21:16]) != i) bad++;
      end
      chk("bp_count", 32'(acc.size()), 32'd64);
      chk("bp_sequence", 32'(bad), 32'd0);

      // Arrival for sensor 3 while its own frame is at zone 30.
      acc.delete();
      pulse(8'h08);
      wait_word(3'd3, 6'd30, "arr");
      pulse(8'h08);
      run_frames(2, 800, "arr");
      chk("arr_count", 32'(acc.size()), 32'd128);
      chk("arr_regrant", 32'(sens_at(64)), 32'd3);

      // Async reset mid-frame with another sensor pending.
      pulse(8'h02);
      wait_word(3'd1, 6'd10, "rstmid");
      pulse(8'h40);
      reset = 1'b0;
      #1;
      chk("rstmid_valid",   32'(out_valid),  32'd0);
      chk("rstmid_busy",    32'(busy),       32'd0);
      chk("rstmid_pending", 32'(pending),    32'd0);
      chk("rstmid_data",    32'(out_data),   32'd0);
      chk("rstmid_zone",    32'(zone_idx),   32'd0);
      chk("rstmid_index",   32'(tof_index),  32'd0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      done_cnt = 0;
      repeat (20) tick();
      chk("rstmid_stays_idle", 32'(busy), 32'd0);
      chk("rstmid_no_done", 32'(done_cnt), 32'd0);

      // Disabled scheduler accumulates pending but never grants.
      enable = 1'b0;
      pulse(8'h11);
      repeat (10) tick();
      chk("dis_busy", 32'(busy), 32'd0);
      chk("dis_pending", 32'(pending), 32'h11);
      enable = 1'b1;
      run_frames(2, 800, "dis");

      // Random traffic.
      acc.delete();
      for (int c = 0; c < 6000; c++) begin
         ready_in  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
         out_ready = ($urandom_range(0, 3) != 0);
         enable    = ($urandom_range(0, 19) != 0);
         tick();
      end
      ready_in = '0; out_ready = 1'b1; enable = 1'b1;
      for (int c = 0; c < 3000 && (e_busy || e_pending != 0); c++) tick();
      chk("rand_drained", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
